// File: rtl/mips_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mips_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   // Which pipeline port owns the access currently in flight.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Arbiter sequencing state.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Width needed to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating counter of consecutive denied cycles for one requester.
module starve_counter
   import mips_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             at_limit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up until the limit is reached.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != limit_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported synchronous memory between the IF and DM ports,
// sequencing the memory's fixed read latency and stalling the loser.
module unified_mem_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   // data memory port
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_done_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   // memory macro
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   // pipeline control
   output logic              stall_if_o,
   output logic              stall_dm_o,
   output logic              busy_o
);

   localparam int               LAT_W    = 3;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
   localparam int               SC_W     = cnt_width(STARVE_MAX);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

   logic final_cyc;
   logic gnt_window;
   logic if_prio;
   logic starve_at_limit;
   logic gnt_if, gnt_dm, any_gnt;
   logic if_rvalid, dm_done;

   // Final latency cycle: read data is on mem_rdata and the port may be re-granted.
   assign final_cyc  = (state_q == ST_BUSY) && (lat_cnt_q == LAT_W'(1));
   assign gnt_window = !rst && ((state_q == ST_IDLE) || final_cyc);

   // Starvation guard only overrides DM priority when it is enabled.
   assign if_prio = (STARVE_MAX != 0) && starve_at_limit;

   // Arbitration: DM first unless IF has been starved; never both in one cycle.
   always_comb begin
      gnt_if = 1'b0;
      gnt_dm = 1'b0;
      if (gnt_window) begin
         if (if_req_i && (!dm_req_i || if_prio)) begin
            gnt_if = 1'b1;
         end else if (dm_req_i) begin
            gnt_dm = 1'b1;
         end
      end
   end

   assign any_gnt = gnt_if || gnt_dm;

   starve_counter #(
      .CNT_W (SC_W)
   ) u_starve (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (if_req_i && !gnt_if),
      .clr_i      (gnt_if || !if_req_i),
      .limit_i    (SC_W'(STARVE_MAX)),
      .at_limit_o (starve_at_limit)
   );

   // Next-state logic: count down the latency, reload on any grant.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            lat_cnt_d = '0;
         end
         ST_BUSY: begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
            if (final_cyc) begin
               state_d = ST_IDLE;
            end
         end
      endcase
      if (any_gnt) begin
         state_d   = ST_BUSY;
         lat_cnt_d = LAT_LOAD;
         owner_d   = gnt_dm ? OWN_DM : OWN_IF;
      end
   end

   // Completion strobes for the owner of the access that is finishing.
   assign if_rvalid = !rst && final_cyc && (owner_q == OWN_IF);
   assign dm_done   = !rst && final_cyc && (owner_q == OWN_DM);

   // Read data capture so each port holds its last word between completions.
   always_comb begin
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (if_rvalid) begin
         if_rdata_d = mem_rdata_i;
      end
      if (dm_done) begin
         dm_rdata_d = mem_rdata_i;
      end
   end

   // State, owner, latency and read-data registers; reset drops any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         lat_cnt_q  <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lat_cnt_q  <= lat_cnt_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Memory strobes are combinational in the grant cycle.
   always_comb begin
      mem_en_o    = any_gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (gnt_dm) begin
         mem_we_o    = dm_we_i;
         mem_addr_o  = dm_addr_i;
         mem_wdata_o = dm_wdata_i;
      end else if (gnt_if) begin
         mem_addr_o  = if_addr_i;
      end
   end

   assign if_gnt_o    = gnt_if;
   assign dm_gnt_o    = gnt_dm;
   assign if_rvalid_o = if_rvalid;
   assign dm_done_o   = dm_done;
   assign if_rdata_o  = rst ? '0 : (if_rvalid ? mem_rdata_i : if_rdata_q);
   assign dm_rdata_o  = rst ? '0 : (dm_done ? mem_rdata_i : dm_rdata_q);
   assign stall_if_o  = !rst && if_req_i && !gnt_if;
   assign stall_dm_o  = !rst && dm_req_i && !gnt_dm;
   assign busy_o      = !rst && (state_q == ST_BUSY);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: four arbiter instances with different latency and
// starvation settings, each with its own memory model, share clk and rst.
module tb_unified_mem_arbiter;

   localparam int NCFG = 4;
   localparam int LAT_TAB [NCFG] = '{1, 2, 3, 1};
   localparam int SM_TAB  [NCFG] = '{4, 4, 4, 0};
   localparam int C_L1 = 0;   // MEM_LAT=1, STARVE_MAX=4
   localparam int C_L2 = 1;   // MEM_LAT=2, STARVE_MAX=4
   localparam int C_L3 = 2;   // MEM_LAT=3, STARVE_MAX=4
   localparam int C_S0 = 3;   // MEM_LAT=1, STARVE_MAX=0

   typedef struct {
      int          cfg;
      bit          is_dm;
      bit          chk_data;
      logic [31:0] data;
      int          due;
   } resp_t;

   resp_t sb [$];
   resp_t mon_e;
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        if_req    [NCFG];
   logic [7:0]  if_addr   [NCFG];
   logic        if_gnt    [NCFG];
   logic        if_rvalid [NCFG];
   logic [31:0] if_rdata  [NCFG];
   logic        dm_req    [NCFG];
   logic        dm_we     [NCFG];
   logic [7:0]  dm_addr   [NCFG];
   logic [31:0] dm_wdata  [NCFG];
   logic        dm_gnt    [NCFG];
   logic        dm_done   [NCFG];
   logic [31:0] dm_rdata  [NCFG];
   logic        mem_en    [NCFG];
   logic        mem_we    [NCFG];
   logic [7:0]  mem_addr  [NCFG];
   logic [31:0] mem_wdata [NCFG];
   logic [31:0] mem_rdata [NCFG];
   logic        stall_if  [NCFG];
   logic        stall_dm  [NCFG];
   logic        busy      [NCFG];

   function automatic logic [31:0] word_of(input logic [7:0] a);
      return {16'hC0DE, a, ~a};
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      logic [31:0] mem  [256];
      logic [31:0] pipe [8];

      initial begin
         for (int a = 0; a < 256; a++) mem[a] = word_of(8'(a));
         for (int i = 0; i < 8; i++) pipe[i] = '0;
      end

      // Synchronous memory with a MEM_LAT-deep read pipeline.
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
         if (mem_en[g] && !mem_we[g]) pipe[0] <= mem[mem_addr[g]];
         for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[LAT_TAB[g]-1];

      unified_mem_arbiter #(
         .ADDR_W     (8),
         .DATA_W     (32),
         .MEM_LAT    (LAT_TAB[g]),
         .STARVE_MAX (SM_TAB[g])
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .if_req_i    (if_req[g]),
         .if_addr_i   (if_addr[g]),
         .if_gnt_o    (if_gnt[g]),
         .if_rvalid_o (if_rvalid[g]),
         .if_rdata_o  (if_rdata[g]),
         .dm_req_i    (dm_req[g]),
         .dm_we_i     (dm_we[g]),
         .dm_addr_i   (dm_addr[g]),
         .dm_wdata_i  (dm_wdata[g]),
         .dm_gnt_o    (dm_gnt[g]),
         .dm_done_o   (dm_done[g]),
         .dm_rdata_o  (dm_rdata[g]),
         .mem_en_o    (mem_en[g]),
         .mem_we_o    (mem_we[g]),
         .mem_addr_o  (mem_addr[g]),
         .mem_wdata_o (mem_wdata[g]),
         .mem_rdata_i (mem_rdata[g]),
         .stall_if_o  (stall_if[g]),
         .stall_dm_o  (stall_dm[g]),
         .busy_o      (busy[g])
      );

      // Requesters must hold their request until granted.
      a_if_hold: assert property (@(posedge clk) disable iff (rst)
         (if_req[g] && !if_gnt[g]) |=> if_req[g])
         else $error("FAIL protocol if_req dropped before grant cfg%0d", g);
      a_dm_hold: assert property (@(posedge clk) disable iff (rst)
         (dm_req[g] && !dm_gnt[g]) |=> dm_req[g])
         else $error("FAIL protocol dm_req dropped before grant cfg%0d", g);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int c, input bit is_dm, input bit chk,
                           input logic [31:0] d, input int due);
      resp_t e;
      e.cfg = c; e.is_dm = is_dm; e.chk_data = chk; e.data = d; e.due = due;
      sb.push_back(e);
   endtask

   // Monitor: every completion pulse must match the oldest expected response.
   always @(negedge clk) begin
      #2;
      for (int c = 0; c < NCFG; c++) begin
         if (if_rvalid[c] || dm_done[c]) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: cfg%0d rvalid=%0b done=%0b with nothing expected (cycle %0d)",
                        c, if_rvalid[c], dm_done[c], cyc);
            end else begin
               mon_e = sb.pop_front();
               check("resp_cfg", 32'(c), 32'(mon_e.cfg));
               check("resp_is_dm", {31'd0, dm_done[c]}, {31'd0, mon_e.is_dm});
               check("resp_cycle", 32'(cyc), 32'(mon_e.due));
               if (mon_e.chk_data)
                  check("resp_data", dm_done[c] ? dm_rdata[c] : if_rdata[c], mon_e.data);
            end
         end
      end
   end

   initial begin
      int max_run;
      int run;
      bit exp_if;

      for (int c = 0; c < NCFG; c++) begin
         if_req[c] = 0; if_addr[c] = '0; dm_req[c] = 0; dm_we[c] = 0;
         dm_addr[c] = '0; dm_wdata[c] = '0;
      end

      // Reset: every output is 0 while rst is high.
      repeat (2) @(negedge clk);
      #1;
      for (int c = 0; c < NCFG; c++) begin
         check("rst_ctrl", {23'd0, if_gnt[c], if_rvalid[c], dm_gnt[c], dm_done[c], mem_en[c],
                            mem_we[c], stall_if[c], stall_dm[c], busy[c]}, 0);
         check("rst_bus", {mem_addr[c], 24'd0} | mem_wdata[c] | if_rdata[c] | dm_rdata[c], 0);
      end
      @(negedge clk);
      rst = 0;

      // IF-only stream on MEM_LAT=1: granted every cycle, no stall.
      for (int a = 0; a < 4; a++) begin
         @(negedge clk);
         if_req[C_L1] = 1; if_addr[C_L1] = 8'(a);
         #1;
         check("t1_if_gnt", if_gnt[C_L1], 1);
         check("t1_stall_if", stall_if[C_L1], 0);
         check("t1_mem_addr", mem_addr[C_L1], a);
         check("t1_mem_we", mem_we[C_L1], 0);
         push_exp(C_L1, 0, 1, word_of(8'(a)), cyc + 1);
      end
      @(negedge clk);
      if_req[C_L1] = 0;
      #1;
      check("t1_gnt_off", if_gnt[C_L1], 0);
      check("t1_busy_tail", busy[C_L1], 1);
      @(negedge clk);
      #1;
      check("t1_busy_clear", busy[C_L1], 0);

      // Collision on MEM_LAT=2: DM first, IF granted in DM's final cycle.
      @(negedge clk);
      if_req[C_L2] = 1; if_addr[C_L2] = 8'h05;
      dm_req[C_L2] = 1; dm_we[C_L2] = 0; dm_addr[C_L2] = 8'h10;
      #1;
      check("t2_dm_gnt", dm_gnt[C_L2], 1);
      check("t2_if_gnt0", if_gnt[C_L2], 0);
      check("t2_stall_if0", stall_if[C_L2], 1);
      check("t2_stall_dm", stall_dm[C_L2], 0);
      check("t2_mem_addr_dm", mem_addr[C_L2], 8'h10);
      push_exp(C_L2, 1, 1, 32'hC0DE10EF, cyc + 2);
      @(negedge clk);
      dm_req[C_L2] = 0;
      #1;
      check("t2_if_gnt1", if_gnt[C_L2], 0);
      check("t2_stall_if1", stall_if[C_L2], 1);
      check("t2_busy", busy[C_L2], 1);
      @(negedge clk);
      #1;
      check("t2_if_gnt2", if_gnt[C_L2], 1);
      check("t2_stall_if2", stall_if[C_L2], 0);
      check("t2_mem_addr_if", mem_addr[C_L2], 8'h05);
      push_exp(C_L2, 0, 1, 32'hC0DE05FA, cyc + 2);
      @(negedge clk);
      if_req[C_L2] = 0;
      #1;
      check("t2_if_gnt3", if_gnt[C_L2], 0);
      repeat (2) @(negedge clk);

      // DM write then read back on MEM_LAT=1.
      @(negedge clk);
      dm_req[C_L1] = 1; dm_we[C_L1] = 1; dm_addr[C_L1] = 8'h20; dm_wdata[C_L1] = 32'hDEADBEEF;
      #1;
      check("t3_wr_gnt", dm_gnt[C_L1], 1);
      check("t3_wr_we", mem_we[C_L1], 1);
      check("t3_wr_wdata", mem_wdata[C_L1], 32'hDEADBEEF);
      push_exp(C_L1, 1, 0, '0, cyc + 1);
      @(negedge clk);
      dm_we[C_L1] = 0;
      #1;
      check("t3_rd_gnt", dm_gnt[C_L1], 1);
      check("t3_rd_we", mem_we[C_L1], 0);
      push_exp(C_L1, 1, 1, 32'hDEADBEEF, cyc + 1);
      @(negedge clk);
      dm_req[C_L1] = 0;
      #1;
      check("t3_idle_we", mem_we[C_L1], 0);
      check("t3_idle_gnt", dm_gnt[C_L1], 0);
      repeat (2) @(negedge clk);

      // Starvation guard on MEM_LAT=1, STARVE_MAX=4: IF wins every fifth cycle.
      max_run = 0;
      run     = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if_req[C_L1] = 1; if_addr[C_L1] = 8'h08;
            dm_req[C_L1] = 1; dm_we[C_L1] = 0; dm_addr[C_L1] = 8'h40;
         end
         #1;
         exp_if = ((k % 5) == 4);
         check("t4_if_gnt", if_gnt[C_L1], exp_if);
         check("t4_dm_gnt", dm_gnt[C_L1], !exp_if);
         run = stall_if[C_L1] ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (exp_if) push_exp(C_L1, 0, 1, 32'hC0DE08F7, cyc + 1);
         else        push_exp(C_L1, 1, 1, 32'hC0DE40BF, cyc + 1);
      end
      check("t4_max_denial", 32'(max_run), 4);
      @(negedge clk);
      dm_req[C_L1] = 0;
      #1;
      check("t4_if_alone", if_gnt[C_L1], 1);
      push_exp(C_L1, 0, 1, 32'hC0DE08F7, cyc + 1);
      @(negedge clk);
      if_req[C_L1] = 0;
      repeat (2) @(negedge clk);

      // STARVE_MAX=0: DM always wins while both request.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if_req[C_S0] = 1; if_addr[C_S0] = 8'h09;
            dm_req[C_S0] = 1; dm_we[C_S0] = 0; dm_addr[C_S0] = 8'h50;
         end
         #1;
         check("t6_dm_gnt", dm_gnt[C_S0], 1);
         check("t6_if_gnt", if_gnt[C_S0], 0);
         check("t6_stall_if", stall_if[C_S0], 1);
         push_exp(C_S0, 1, 1, 32'hC0DE50AF, cyc + 1);
      end
      @(negedge clk);
      dm_req[C_S0] = 0;
      #1;
      check("t6_if_after_dm", if_gnt[C_S0], 1);
      push_exp(C_S0, 0, 1, 32'hC0DE09F6, cyc + 1);
      @(negedge clk);
      if_req[C_S0] = 0;
      repeat (2) @(negedge clk);

      // Reset one cycle after a MEM_LAT=3 grant: access dropped, fresh IF granted at once.
      @(negedge clk);
      dm_req[C_L3] = 1; dm_we[C_L3] = 0; dm_addr[C_L3] = 8'h30;
      #1;
      check("t5_dm_gnt", dm_gnt[C_L3], 1);
      @(negedge clk);
      rst = 1;
      dm_req[C_L3] = 0;
      if_req[C_L3] = 1; if_addr[C_L3] = 8'h02;
      #1;
      check("t5_rst_ctrl", {24'd0, if_gnt[C_L3], if_rvalid[C_L3], dm_gnt[C_L3], dm_done[C_L3],
                            mem_en[C_L3], stall_if[C_L3], stall_dm[C_L3], busy[C_L3]}, 0);
      check("t5_rst_addr", mem_addr[C_L3], 0);
      @(negedge clk);
      rst = 0;
      #1;
      check("t5_busy_after", busy[C_L3], 0);
      check("t5_if_gnt", if_gnt[C_L3], 1);
      check("t5_mem_addr", mem_addr[C_L3], 8'h02);
      push_exp(C_L3, 0, 1, 32'hC0DE02FD, cyc + 3);
      @(negedge clk);
      if_req[C_L3] = 0;
      repeat (6) @(negedge clk);

      check("sb_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
